// File: rtl/mixer_pipe_pkg.sv
// Shared fixed-point formats, saturation limits and bus types for the
// pipelined LO mixer.
package mixer_pipe_pkg;

  localparam int FIXDT_24_WIDTH      = 24;
  localparam int FIXDT_24_FRAC_WIDTH = 16;
  localparam int MIXER_MAX_CH        = 8;

  localparam logic signed [FIXDT_24_WIDTH-1:0] FIXDT_24_MAX = 24'sh7fffff;
  localparam logic signed [FIXDT_24_WIDTH-1:0] FIXDT_24_MIN = 24'sh800000;

  typedef logic signed [FIXDT_24_WIDTH-1:0] fixdt_24_t;
  typedef logic [MIXER_MAX_CH-1:0][FIXDT_24_WIDTH-1:0] ch_bus_t;

endpackage

// File: rtl/mixer_pipe_fix_round_sat.sv
// Combinational rescale of a full-width signed product back to the data
// format: optional round-half-up, arithmetic shift, then saturation.
module fix_round_sat
  import mixer_pipe_pkg::*;
#(
  parameter int W = FIXDT_24_WIDTH,
  parameter int F = FIXDT_24_FRAC_WIDTH
) (
  input  logic signed [2*W-1:0] prod,
  input  logic                  round_en,
  output logic [W-1:0]          res,
  output logic                  ovf,
  output logic                  unf
);

  // One guard bit above the product so the rounding add cannot wrap.
  localparam logic signed [2*W:0] R_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] R_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [2*W:0] HALF  = {{(2*W+1-F){1'b0}}, 1'b1, {(F-1){1'b0}}};

  logic signed [2*W:0] ext_s;
  logic signed [2*W:0] rnd_s;
  logic signed [2*W:0] shr_s;

  // Round, rescale and clamp to the representable range.
  always_comb begin
    ext_s = {prod[2*W-1], prod};
    if (round_en) begin
      rnd_s = ext_s + HALF;
    end else begin
      rnd_s = ext_s;
    end
    shr_s = rnd_s >>> F;
    if (shr_s > R_MAX) begin
      res = {1'b0, {(W-1){1'b1}}};
      ovf = 1'b1;
      unf = 1'b0;
    end else if (shr_s < R_MIN) begin
      res = {1'b1, {(W-1){1'b0}}};
      ovf = 1'b0;
      unf = 1'b1;
    end else begin
      res = shr_s[W-1:0];
      ovf = 1'b0;
      unf = 1'b0;
    end
  end

endmodule

// File: rtl/mixer_pipe.sv
// Two-stage multi-channel fixed-point mixer: shared sample times per-channel
// LO, with round/saturate, sticky overflow flags and a saturation counter.
module mixer_pipe
  import mixer_pipe_pkg::*;
#(
  parameter int DATA_WIDTH      = FIXDT_24_WIDTH,
  parameter int DATA_FRAC_WIDTH = FIXDT_24_FRAC_WIDTH,
  parameter int NUM_CH          = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_sample,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_lo,
  input  logic                         round_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  input  logic                         clr_flags,
  output logic [NUM_CH-1:0]            ovf_sticky,
  output logic [NUM_CH-1:0]            unf_sticky,
  output logic [CNT_WIDTH-1:0]         sat_count
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                          adv_s;
  logic signed [PW-1:0]          prod_s [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0]  res_s;
  logic [NUM_CH-1:0]             ovf_s;
  logic [NUM_CH-1:0]             unf_s;
  logic [NUM_CH-1:0]             ev_ovf_s;
  logic [NUM_CH-1:0]             ev_unf_s;
  logic                          sat_ev_s;

  logic                          s1_valid_r;
  logic                          s1_round_r;
  logic signed [PW-1:0]          s1_prod_r [NUM_CH];
  logic                          out_valid_r;
  logic [NUM_CH*DATA_WIDTH-1:0]  out_data_r;
  logic [NUM_CH-1:0]             ovf_r;
  logic [NUM_CH-1:0]             unf_r;
  logic [CNT_WIDTH-1:0]          cnt_r;

  assign adv_s    = !out_valid_r || out_ready;
  assign in_ready = adv_s;

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      assign prod_s[k] =
        $signed({{DATA_WIDTH{in_lo[k*DATA_WIDTH+DATA_WIDTH-1]}}, in_lo[k*DATA_WIDTH +: DATA_WIDTH]}) *
        $signed({{DATA_WIDTH{in_sample[DATA_WIDTH-1]}}, in_sample});

      fix_round_sat #(
        .W (DATA_WIDTH),
        .F (DATA_FRAC_WIDTH)
      ) u_rs (
        .prod     (s1_prod_r[k]),
        .round_en (s1_round_r),
        .res      (res_s[k*DATA_WIDTH +: DATA_WIDTH]),
        .ovf      (ovf_s[k]),
        .unf      (unf_s[k])
      );
    end
  endgenerate

  // Stage 1: full-precision products and the rounding mode of the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_round_r <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        s1_prod_r[i] <= {PW{1'b0}};
      end
    end else if (adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_round_r <= round_en;
        for (int i = 0; i < NUM_CH; i++) begin
          s1_prod_r[i] <= prod_s[i];
        end
      end
    end
  end

  // Stage 2: rescaled, saturated results held until downstream takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(NUM_CH*DATA_WIDTH){1'b0}};
    end else if (adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_data_r <= res_s;
      end
    end
  end

  // Events qualify only on the cycle a real beat enters the output stage.
  always_comb begin
    ev_ovf_s = {NUM_CH{1'b0}};
    ev_unf_s = {NUM_CH{1'b0}};
    if (adv_s && s1_valid_r) begin
      ev_ovf_s = ovf_s;
      ev_unf_s = unf_s;
    end else begin
      ev_ovf_s = {NUM_CH{1'b0}};
      ev_unf_s = {NUM_CH{1'b0}};
    end
    sat_ev_s = |(ev_ovf_s | ev_unf_s);
  end

  // Sticky flags and saturating event counter; a same-cycle event beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= {NUM_CH{1'b0}};
      unf_r <= {NUM_CH{1'b0}};
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (clr_flags) begin
      ovf_r <= ev_ovf_s;
      unf_r <= ev_unf_s;
      cnt_r <= sat_ev_s ? CNT_ONE : {CNT_WIDTH{1'b0}};
    end else begin
      ovf_r <= ovf_r | ev_ovf_s;
      unf_r <= unf_r | ev_unf_s;
      if (sat_ev_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign ovf_sticky = ovf_r;
  assign unf_sticky = unf_r;
  assign sat_count  = cnt_r;

endmodule

// File: tb/tb_mixer_pipe.sv
// Directed self-checking bench for mixer_pipe (NUM_CH=2, Q8.16).
module tb_mixer_pipe;
  import mixer_pipe_pkg::*;

  localparam int W  = FIXDT_24_WIDTH;
  localparam int NC = 2;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_sample;
  logic [NC*W-1:0] in_lo;
  logic            round_en;
  logic            out_valid;
  logic            out_ready;
  logic [NC*W-1:0] out_data;
  logic            clr_flags;
  logic [NC-1:0]   ovf_sticky;
  logic [NC-1:0]   unf_sticky;
  logic [CW-1:0]   sat_count;

  int checks = 0;
  int errors = 0;

  mixer_pipe #(
    .DATA_WIDTH      (W),
    .DATA_FRAC_WIDTH (FIXDT_24_FRAC_WIDTH),
    .NUM_CH          (NC),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .in_lo      (in_lo),
    .round_en   (round_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .clr_flags  (clr_flags),
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_sample = 24'h123456; in_lo = 48'h010000_010000;
    round_en = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %h want 0", out_valid); end
    checks++; if (out_data !== 48'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (ovf_sticky !== 2'b00 || unf_sticky !== 2'b00) begin errors++; $display("FAIL reset_flags got %b/%b want 00/00", ovf_sticky, unf_sticky); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_sat_count got %0d want 0", sat_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %h want 1", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_sample = 24'h000018; in_lo = {24'h018000, 24'h010000}; round_en = 1'b0;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency1 got %h want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency2 got %h want 1", out_valid); end
    checks++; if (out_data !== {24'h000024, 24'h000018}) begin errors++; $display("FAIL basic_data got %h want %h", out_data, {24'h000024, 24'h000018}); end
    checks++; if (ovf_sticky !== 2'b00 || unf_sticky !== 2'b00) begin errors++; $display("FAIL basic_flags got %b/%b want 00/00", ovf_sticky, unf_sticky); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_bubble got %h want 0", out_valid); end
  endtask

  task automatic test_rounding();
    logic [W-1:0]    smp [4] = '{24'h000001, 24'h000001, 24'hffffff, 24'hffffff};
    logic            rnd [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [NC*W-1:0] exp [4] = '{48'h000000_000000, 48'h000001_000001, 48'hffffff_ffffff, 48'h000000_000000};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_sample = smp[i]; in_lo = {24'h008000, 24'h008000}; round_en = rnd[i];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        checks++; if (out_valid !== 1'b1 || out_data !== exp[i-1]) begin errors++; $display("FAIL rounding_beat%0d got v=%h %h want v=1 %h", i-1, out_valid, out_data, exp[i-1]); end
      end
    end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL rounding_no_sat got %0d want 0", sat_count); end
  endtask

  task automatic test_saturation();
    logic [W-1:0]    smp [3] = '{24'h7fffff, 24'h800000, 24'h800000};
    logic [NC*W-1:0] lo  [3] = '{{24'h010000, 24'h010001}, {24'h010000, 24'h010001}, {24'h010000, 24'h800000}};
    logic [NC*W-1:0] exp [3] = '{{24'h7fffff, 24'h7fffff}, {24'h800000, 24'h800000}, {24'h800000, 24'h7fffff}};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        in_valid = 1'b1; in_sample = smp[i]; in_lo = lo[i]; round_en = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        checks++; if (out_valid !== 1'b1 || out_data !== exp[i-1]) begin errors++; $display("FAIL sat_beat%0d got v=%h %h want v=1 %h", i-1, out_valid, out_data, exp[i-1]); end
      end
    end
    checks++; if (sat_count !== 16'd3) begin errors++; $display("FAIL sat_count got %0d want 3", sat_count); end
    checks++; if (ovf_sticky !== 2'b01) begin errors++; $display("FAIL sat_ovf got %b want 01", ovf_sticky); end
    checks++; if (unf_sticky !== 2'b01) begin errors++; $display("FAIL sat_unf got %b want 01", unf_sticky); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]    smp [5] = '{24'h000100, 24'h500000, 24'h000003, 24'hb00000, 24'h123456};
    logic [NC*W-1:0] exp [5] = '{48'h000100_000200, 48'h500000_7fffff, 48'h000003_000006,
                                 48'hb00000_800000, 48'h123456_2468ac};
    int ii = 0;
    int oi = 0;
    logic fire_in, fire_out, stalled, prev_stall;
    logic [NC*W-1:0] held, cap;
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    checks++; if (sat_count !== 16'd0 || ovf_sticky !== 2'b00 || unf_sticky !== 2'b00) begin errors++; $display("FAIL bp_clear got %0d %b %b want 0 00 00", sat_count, ovf_sticky, unf_sticky); end
    prev_stall = 1'b0; held = '0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (ii < 5) begin
        in_valid = 1'b1; in_sample = smp[ii]; in_lo = {24'h010000, 24'h020000}; round_en = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      stalled  = out_valid && !out_ready;
      if (stalled) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d got %h want 0", c, in_ready); end
        if (prev_stall) begin
          checks++; if (out_data !== held) begin errors++; $display("FAIL bp_stable c=%0d got %h want %h", c, out_data, held); end
        end
        held = out_data;
      end
      prev_stall = stalled;
      cap = out_data;
      step();
      if (fire_in) ii++;
      if (fire_out) begin
        if (oi < 5) begin
          checks++; if (cap !== exp[oi]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", oi, cap, exp[oi]); end
        end
        oi++;
      end
      if (ii == 5 && oi >= 5) break;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    checks++; if (oi != 5) begin errors++; $display("FAIL bp_delivered got %0d want 5", oi); end
    checks++; if (sat_count !== 16'd2) begin errors++; $display("FAIL bp_sat_count got %0d want 2", sat_count); end
    checks++; if (ovf_sticky !== 2'b01 || unf_sticky !== 2'b01) begin errors++; $display("FAIL bp_flags got %b/%b want 01/01", ovf_sticky, unf_sticky); end
    step();
  endtask

  task automatic test_clear_collision();
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    in_valid = 1'b1; in_sample = 24'h7fffff; in_lo = {24'h010000, 24'h010001}; round_en = 1'b0;
    step();
    in_valid = 1'b0; clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    checks++; if (ovf_sticky !== 2'b01 || unf_sticky !== 2'b00) begin errors++; $display("FAIL coll_flags got %b/%b want 01/00", ovf_sticky, unf_sticky); end
    checks++; if (sat_count !== 16'd1) begin errors++; $display("FAIL coll_count got %0d want 1", sat_count); end
    checks++; if (out_valid !== 1'b1 || out_data !== 48'h7fffff_7fffff) begin errors++; $display("FAIL coll_data got v=%h %h want v=1 7fffff7fffff", out_valid, out_data); end
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    checks++; if (ovf_sticky !== 2'b00 || sat_count !== 16'd0) begin errors++; $display("FAIL coll_clear got %b %0d want 00 0", ovf_sticky, sat_count); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sample = 24'h7fffff; in_lo = {24'h010000, 24'h010001}; round_en = 1'b0;
    step();
    in_sample = 24'h000018; in_lo = {24'h010000, 24'h018000};
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || ovf_sticky !== 2'b01) begin errors++; $display("FAIL rmid_pre got v=%h ovf=%b want v=1 ovf=01", out_valid, ovf_sticky); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %h want 0", out_valid); end
    checks++; if (ovf_sticky !== 2'b00 || unf_sticky !== 2'b00 || sat_count !== 16'd0) begin errors++; $display("FAIL rmid_flags got %b %b %0d want 00 00 0", ovf_sticky, unf_sticky, sat_count); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_ghost c=%0d got %h want 0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_clear_collision();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
